// File: rtl/fifo_block_packer_if.sv
// Handshake bundle between the upstream FIFO read port, the block packer and the
// downstream block consumer. The master side is the packer itself.
interface fifo_block_packer_if #(
    parameter int DWIDTH = 16,
    parameter int BWIDTH = 128
);
    logic              fifo_rempty;
    logic              fifo_rrq;
    logic [DWIDTH-1:0] fifo_rdata;
    logic              blk_valid;
    logic              blk_ready;
    logic [BWIDTH-1:0] blk_data;

    modport master (
        input  fifo_rempty,
        input  fifo_rdata,
        input  blk_ready,
        output fifo_rrq,
        output blk_valid,
        output blk_data
    );

    modport slave (
        output fifo_rempty,
        output fifo_rdata,
        output blk_ready,
        input  fifo_rrq,
        input  blk_valid,
        input  blk_data
    );
endinterface

// File: rtl/fifo_block_packer.sv
// Gathers NW consecutive FIFO read words into one BWIDTH block (first word in the
// MSBs) and holds it with valid/ready until the downstream consumer takes it.
module fifo_block_packer #(
    parameter int DWIDTH = 16,
    parameter int BWIDTH = 128
) (
    input  logic                                rclk_i,
    input  logic                                arst_n_i,
    input  logic                                clr_i,
    fifo_block_packer_if.master                 bus,
    output logic [$clog2(BWIDTH/DWIDTH):0]      fill_lvl_o,
    output logic [15:0]                         blk_cnt_o
);
    localparam int NW = BWIDTH / DWIDTH;
    localparam int CW = $clog2(NW) + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t            state_q;
    logic              run_q;
    logic              pend_q;
    logic [CW-1:0]     issued_q;
    logic [CW-1:0]     fill_q;
    logic              blk_valid_q;
    logic [BWIDTH-1:0] blk_data_q;
    logic [BWIDTH-1:0] blk_data_d;
    logic [15:0]       blk_cnt_q;

    logic rrq;
    logic capture;
    logic last_word;
    logic hshake;

    // run_q keeps requests off until the first edge after reset release.
    always_comb begin
        rrq       = (state_q == FILL) && run_q && !bus.fifo_rempty &&
                    (issued_q < CW'(NW)) && !clr_i;
        capture   = (state_q == FILL) && pend_q;
        last_word = capture && (fill_q == CW'(NW - 1));
        hshake    = blk_valid_q && bus.blk_ready;
    end

    for (genvar gi = 0; gi < NW; gi++) begin : g_lane
        assign blk_data_d[BWIDTH-1-gi*DWIDTH -: DWIDTH] =
            (capture && (fill_q == CW'(gi))) ? bus.fifo_rdata
                                             : blk_data_q[BWIDTH-1-gi*DWIDTH -: DWIDTH];
    end

    always_ff @(posedge rclk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= FILL;
            run_q       <= 1'b0;
            pend_q      <= 1'b0;
            issued_q    <= '0;
            fill_q      <= '0;
            blk_valid_q <= 1'b0;
            blk_data_q  <= '0;
            blk_cnt_q   <= '0;
        end else begin
            run_q <= 1'b1;
            if (clr_i) begin
                // Abort wins over a same-cycle handshake; an in-flight read is dropped.
                state_q     <= FILL;
                pend_q      <= 1'b0;
                issued_q    <= '0;
                fill_q      <= '0;
                blk_valid_q <= 1'b0;
            end else if (state_q == HOLD) begin
                if (hshake) begin
                    state_q     <= FILL;
                    issued_q    <= '0;
                    fill_q      <= '0;
                    blk_valid_q <= 1'b0;
                    blk_cnt_q   <= blk_cnt_q + 16'd1;
                end
            end else begin
                pend_q <= rrq;
                if (rrq) begin
                    issued_q <= issued_q + CW'(1);
                end
                if (capture) begin
                    blk_data_q <= blk_data_d;
                    fill_q     <= fill_q + CW'(1);
                end
                if (last_word) begin
                    state_q     <= HOLD;
                    blk_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.fifo_rrq  = rrq;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_data  = blk_data_q;
    assign fill_lvl_o    = fill_q;
    assign blk_cnt_o     = blk_cnt_q;
endmodule
